// File: rtl/pong_game_core.sv
// Pong game-state engine: ball, paddles, scores and match state, advanced once per frame_tick.
// Five-zone paddle deflection, wall bounce, serve delay and first-to-WIN_SCORE match handling.
module pong_game_core #(
    parameter int FRAME_W     = 640,
    parameter int FRAME_H     = 480,
    parameter int BALL_SIZE   = 10,
    parameter int PAD_W       = 12,
    parameter int PAD_H       = 60,
    parameter int P1_X        = 13,
    parameter int P2_X        = 615,
    parameter int PAD_STEP    = 4,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4
) (
    input  logic               CLOCK_25,
    input  logic               RESET_N,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               p2_up,
    input  logic               p2_down,
    output logic [11:0]        ball_x,
    output logic [11:0]        ball_y,
    output logic [11:0]        pad1_y,
    output logic [11:0]        pad2_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         state,
    output logic [1:0]         winner,
    output logic               point_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic signed [12:0] FW_S   = 13'(FRAME_W);
    localparam logic signed [12:0] FH_S   = 13'(FRAME_H);
    localparam logic signed [12:0] BS_S   = 13'(BALL_SIZE);
    localparam logic signed [12:0] HB_S   = 13'(BALL_SIZE / 2);
    localparam logic signed [12:0] PH_S   = 13'(PAD_H);
    localparam logic signed [12:0] P1E_S  = 13'(P1_X + PAD_W);
    localparam logic signed [12:0] P2X_S  = 13'(P2_X);
    localparam logic signed [12:0] STEP_S = 13'(PAD_STEP);
    localparam logic signed [12:0] PMAX_S = 13'(FRAME_H - PAD_H);
    localparam logic signed [12:0] ZW1_S  = 13'(PAD_H / 5);
    localparam logic signed [12:0] ZW2_S  = 13'(2 * (PAD_H / 5));
    localparam logic signed [12:0] ZW3_S  = 13'(3 * (PAD_H / 5));
    localparam logic signed [12:0] ZW4_S  = 13'(4 * (PAD_H / 5));
    localparam logic [11:0] BX0  = 12'((FRAME_W - BALL_SIZE) / 2);
    localparam logic [11:0] BY0  = 12'((FRAME_H - BALL_SIZE) / 2);
    localparam logic [11:0] PAD0 = 12'((FRAME_H - PAD_H) / 2);
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0]   SERVE_V = CNT_W'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] WIN_V   = SCORE_W'(WIN_SCORE);

    function automatic logic [11:0] pad_next(input logic [11:0] y, input logic up, input logic dn);
        logic signed [12:0] ys;
        ys = $signed({1'b0, y});
        if (up && !dn) begin
            if (ys < STEP_S) ys = 13'sd0;
            else             ys = ys - STEP_S;
        end else if (dn && !up) begin
            if (ys + STEP_S > PMAX_S) ys = PMAX_S;
            else                      ys = ys + STEP_S;
        end else begin
            ys = ys;
        end
        return 12'(ys);
    endfunction

    function automatic logic [2:0] zone_of(input logic signed [12:0] by, input logic signed [12:0] py);
        logic signed [12:0] off;
        off = by + HB_S - py;
        if (off < 13'sd0)               off = 13'sd0;
        else if (off > PH_S - 13'sd1)   off = PH_S - 13'sd1;
        else                            off = off;
        if (off < ZW1_S)      return 3'd0;
        else if (off < ZW2_S) return 3'd1;
        else if (off < ZW3_S) return 3'd2;
        else if (off < ZW4_S) return 3'd3;
        else                  return 3'd4;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s < WIN_V) ? s + SCORE_W'(1) : s;
    endfunction

    state_e             state_q, state_d;
    logic [11:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [11:0]        pad1_q, pad1_d, pad2_q, pad2_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [1:0]         winner_q, winner_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [2:0]         vx_q, vx_d, vy_q, vy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               point_q, point_d;

    logic signed [12:0] bx_s, by_s, p1_s, p2_s, vx_s, vy_s;
    logic [11:0]        ny_s;
    logic               ndy_s, hit1_s, hit2_s, miss1_s, miss2_s;
    logic [2:0]         zone_s;
    logic [SCORE_W-1:0] s1_inc_s, s2_inc_s;

    assign bx_s = $signed({1'b0, ball_x_q});
    assign by_s = $signed({1'b0, ball_y_q});
    assign p1_s = $signed({1'b0, pad1_q});
    assign p2_s = $signed({1'b0, pad2_q});
    assign vx_s = $signed({10'd0, vx_q});
    assign vy_s = $signed({10'd0, vy_q});

    // Collision and miss tests all use pre-tick ball and paddle positions.
    assign hit1_s  = !dir_x_q && (bx_s >= P1E_S) && (bx_s - vx_s <= P1E_S)
                     && (by_s + BS_S > p1_s) && (by_s < p1_s + PH_S);
    assign hit2_s  = dir_x_q && (bx_s + BS_S <= P2X_S) && (bx_s + BS_S + vx_s >= P2X_S)
                     && (by_s + BS_S > p2_s) && (by_s < p2_s + PH_S);
    assign miss1_s = !dir_x_q && (bx_s < vx_s);
    assign miss2_s = dir_x_q && (bx_s + BS_S + vx_s > FW_S);
    assign zone_s  = zone_of(by_s, hit1_s ? p1_s : p2_s);
    assign s1_inc_s = sat_inc(score1_q);
    assign s2_inc_s = sat_inc(score2_q);

    // Vertical step with top/bottom wall reflection.
    always_comb begin
        ny_s  = ball_y_q;
        ndy_s = dir_y_q;
        if (!dir_y_q && (by_s < vy_s)) begin
            ny_s  = 12'd0;
            ndy_s = 1'b1;
        end else if (dir_y_q && (by_s + BS_S + vy_s > FH_S)) begin
            ny_s  = 12'(FH_S - BS_S);
            ndy_s = 1'b0;
        end else if (dir_y_q) begin
            ny_s = 12'(by_s + vy_s);
        end else begin
            ny_s = 12'(by_s - vy_s);
        end
    end

    // Match FSM and per-frame object update.
    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        pad1_d   = pad1_q;
        pad2_d   = pad2_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        cnt_d    = cnt_q;
        point_d  = 1'b0;
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SERVE;
                        cnt_d   = SERVE_V;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    pad1_d   = pad_next(pad1_q, p1_up, p1_down);
                    pad2_d   = pad_next(pad2_q, p2_up, p2_down);
                    ball_x_d = BX0;
                    ball_y_d = BY0;
                    vx_d     = 3'd4;
                    vy_d     = 3'd0;
                    if (cnt_q == {CNT_W{1'b0}}) state_d = ST_PLAY;
                    else                        cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_PLAY: begin
                    pad1_d   = pad_next(pad1_q, p1_up, p1_down);
                    pad2_d   = pad_next(pad2_q, p2_up, p2_down);
                    ball_y_d = ny_s;
                    dir_y_d  = ndy_s;
                    if (hit1_s || hit2_s) begin
                        ball_x_d = hit1_s ? 12'(P1E_S) : 12'(P2X_S - BS_S);
                        dir_x_d  = hit1_s;
                        case (zone_s)
                            3'd0:    begin vx_d = 3'd2; vy_d = 3'd2; dir_y_d = 1'b0; end
                            3'd1:    begin vx_d = 3'd3; vy_d = 3'd1; dir_y_d = 1'b0; end
                            3'd2:    begin vx_d = 3'd4; vy_d = 3'd0; end
                            3'd3:    begin vx_d = 3'd3; vy_d = 3'd1; dir_y_d = 1'b1; end
                            default: begin vx_d = 3'd2; vy_d = 3'd2; dir_y_d = 1'b1; end
                        endcase
                    end else if (miss1_s || miss2_s) begin
                        // Point: re-centre and serve toward the player who conceded.
                        point_d  = 1'b1;
                        ball_x_d = BX0;
                        ball_y_d = BY0;
                        vx_d     = 3'd4;
                        vy_d     = 3'd0;
                        cnt_d    = SERVE_V;
                        dir_x_d  = miss2_s;
                        state_d  = ST_SERVE;
                        if (miss2_s) begin
                            score1_d = s1_inc_s;
                            if (s1_inc_s == WIN_V) begin
                                state_d  = ST_OVER;
                                winner_d = 2'b01;
                            end else begin
                                state_d  = ST_SERVE;
                            end
                        end else begin
                            score2_d = s2_inc_s;
                            if (s2_inc_s == WIN_V) begin
                                state_d  = ST_OVER;
                                winner_d = 2'b10;
                            end else begin
                                state_d  = ST_SERVE;
                            end
                        end
                    end else begin
                        ball_x_d = dir_x_q ? 12'(bx_s + vx_s) : 12'(bx_s - vx_s);
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_d  = ST_SERVE;
                        cnt_d    = SERVE_V;
                        score1_d = {SCORE_W{1'b0}};
                        score2_d = {SCORE_W{1'b0}};
                        winner_d = 2'b00;
                    end else begin
                        state_d = ST_OVER;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            point_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            ball_x_q <= BX0;
            ball_y_q <= BY0;
            pad1_q   <= PAD0;
            pad2_q   <= PAD0;
            score1_q <= {SCORE_W{1'b0}};
            score2_q <= {SCORE_W{1'b0}};
            winner_q <= 2'b00;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            vx_q     <= 3'd4;
            vy_q     <= 3'd0;
            cnt_q    <= {CNT_W{1'b0}};
            point_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            pad1_q   <= pad1_d;
            pad2_q   <= pad2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            cnt_q    <= cnt_d;
            point_q  <= point_d;
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign pad1_y      = pad1_q;
    assign pad2_y      = pad2_q;
    assign score1      = score1_q;
    assign score2      = score2_q;
    assign state       = state_q;
    assign winner      = winner_q;
    assign point_pulse = point_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core (WIN_SCORE=2): reset, clamp, serve, deflection, wall, miss/win, async reset.
module tb_pong_game_core;

    logic        CLOCK_25 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic [11:0] ball_x, ball_y, pad1_y, pad2_y;
    logic [3:0]  score1, score2;
    logic [1:0]  state, winner;
    logic        point_pulse;

    int checks = 0;
    int errors = 0;

    always #20 CLOCK_25 = ~CLOCK_25;

    pong_game_core #(.WIN_SCORE(2)) dut (
        .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .frame_tick(frame_tick), .start(start),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .ball_x(ball_x), .ball_y(ball_y), .pad1_y(pad1_y), .pad2_y(pad2_y),
        .score1(score1), .score2(score2), .state(state), .winner(winner),
        .point_pulse(point_pulse)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame_tick pulse; returns on the following falling edge with outputs settled.
    task automatic tick();
        @(negedge CLOCK_25);
        frame_tick = 1'b1;
        @(negedge CLOCK_25);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_dut();
        @(negedge CLOCK_25);
        RESET_N = 1'b0;
        @(negedge CLOCK_25);
        RESET_N = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge CLOCK_25);
        chk("rst_ball_x", ball_x, 16'd315);
        chk("rst_ball_y", ball_y, 16'd235);
        chk("rst_pad1", pad1_y, 16'd210);
        chk("rst_pad2", pad2_y, 16'd210);
        chk("rst_score1", score1, 16'd0);
        chk("rst_score2", score2, 16'd0);
        chk("rst_state", state, 16'd0);
        chk("rst_winner", winner, 16'd0);
        chk("rst_point", point_pulse, 16'd0);
        RESET_N = 1'b1;

        tick();
        chk("idle_no_start", state, 16'd0);

        // Serve and paddle clamp.
        start = 1'b1; tick(); start = 1'b0;
        chk("serve_enter", state, 16'd1);
        p1_up = 1'b1; p1_down = 1'b1; tick();
        chk("pad_both_hold", pad1_y, 16'd210);
        p1_down = 1'b0; ticks(52);
        chk("pad_up_52", pad1_y, 16'd2);
        tick();
        chk("pad_up_floor", pad1_y, 16'd0);
        ticks(6);
        chk("pad_floor_held", pad1_y, 16'd0);
        chk("serve_60_ticks", state, 16'd1);
        p1_up = 1'b0; tick();
        chk("play_enter", state, 16'd2);
        chk("serve_ball_x", ball_x, 16'd315);
        tick();
        chk("play_first_x", ball_x, 16'd319);
        chk("play_first_y", ball_y, 16'd235);
        repeat (5) @(negedge CLOCK_25);
        chk("no_tick_hold", ball_x, 16'd319);

        // Asynchronous reset between clock edges.
        @(posedge CLOCK_25); #5;
        RESET_N = 1'b0; #1;
        chk("async_ball_x", ball_x, 16'd315);
        chk("async_state", state, 16'd0);
        chk("async_pad1", pad1_y, 16'd210);
        @(negedge CLOCK_25);
        RESET_N = 1'b1;

        // Centre hit on pad2: zone 2, straight return.
        start = 1'b1; tick(); start = 1'b0;
        ticks(61);
        chk("b_play", state, 16'd2);
        ticks(72);
        chk("b_pre_hit_x", ball_x, 16'd603);
        tick();
        chk("b_hit_x", ball_x, 16'd605);
        tick();
        chk("b_ret_x", ball_x, 16'd601);
        chk("b_ret_y", ball_y, 16'd235);
        reset_dut();

        // Edge hit on pad2 at 230: zone 0 (vx2 vy2 up), then top wall bounce.
        start = 1'b1; tick(); start = 1'b0;
        p2_down = 1'b1; ticks(5); p2_down = 1'b0;
        chk("z0_pad2", pad2_y, 16'd230);
        ticks(56);
        chk("z0_play", state, 16'd2);
        ticks(73);
        chk("z0_hit_x", ball_x, 16'd605);
        tick();
        chk("z0_ret_x", ball_x, 16'd603);
        chk("z0_ret_y", ball_y, 16'd233);
        ticks(117);
        chk("wall_y", ball_y, 16'd0);
        chk("wall_x", ball_x, 16'd369);
        tick();
        chk("wall_after_y", ball_y, 16'd2);
        chk("wall_after_x", ball_x, 16'd367);
        reset_dut();

        // Miss past pad2 at 0, twice, to win.
        start = 1'b1; tick(); start = 1'b0;
        p2_up = 1'b1; ticks(53);
        chk("c_pad2_floor", pad2_y, 16'd0);
        ticks(8); p2_up = 1'b0;
        chk("c_play", state, 16'd2);
        ticks(78);
        chk("c_pre_miss_x", ball_x, 16'd627);
        tick();
        chk("c_score1", score1, 16'd1);
        chk("c_score2", score2, 16'd0);
        chk("c_pulse", point_pulse, 16'd1);
        chk("c_reserve_state", state, 16'd1);
        chk("c_reserve_x", ball_x, 16'd315);
        @(negedge CLOCK_25);
        chk("c_pulse_one_cycle", point_pulse, 16'd0);
        ticks(61);
        chk("c_play2", state, 16'd2);
        tick();
        chk("c_serve_right", ball_x, 16'd319);
        ticks(77);
        tick();
        chk("c_over", state, 16'd3);
        chk("c_winner", winner, 16'd1);
        chk("c_final_score1", score1, 16'd2);
        chk("c_pulse2", point_pulse, 16'd1);
        tick();
        chk("over_hold", state, 16'd3);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_state", state, 16'd1);
        chk("restart_score1", score1, 16'd0);
        chk("restart_winner", winner, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
